// File: rtl/dot_product_scheduler.sv
// dot_product_scheduler: walks an M_ROWS x N_COLS operand grid and tags datapath results.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start launches a pass;
// i_pause stalls issue; o_busy pass active; o_issue/o_row_idx/o_col_idx operand strobe;
// o_result_valid/o_result_row/o_result_col tagged datapath output; o_done end-of-pass pulse.
module dot_product_scheduler #(
  parameter int M_ROWS  = 4,
  parameter int N_COLS  = 4,
  parameter int LATENCY = 3,
  localparam int RW = (M_ROWS > 1) ? $clog2(M_ROWS) : 1,
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_pause,
  output logic          o_busy,
  output logic          o_issue,
  output logic [RW-1:0] o_row_idx,
  output logic [CW-1:0] o_col_idx,
  output logic          o_result_valid,
  output logic [RW-1:0] o_result_row,
  output logic [CW-1:0] o_result_col,
  output logic          o_done
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  localparam logic [RW-1:0] ROW_LAST = RW'(M_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  state_t              r_state;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [LATENCY-1:0]  r_vld;
  logic [RW-1:0]       r_trow [LATENCY];
  logic [CW-1:0]       r_tcol [LATENCY];
  logic                w_issue;
  logic [LATENCY-1:0]  w_vld_nxt;
  assign w_issue   = (r_state == S_ISSUE) && !i_pause;
  assign w_vld_nxt = (r_vld << 1) | LATENCY'(w_issue);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_ISSUE;
          r_row   <= '0;
          r_col   <= '0;
        end
        S_ISSUE: if (w_issue) begin
          if (r_row == ROW_LAST && r_col == COL_LAST) r_state <= S_DRAIN;
          else if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else r_col <= r_col + CW'(1);
        end
        // Leave when the stages will all be empty next cycle, so DONE follows the last result.
        S_DRAIN: if (w_vld_nxt == '0) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_trow[i] <= '0;
        r_tcol[i] <= '0;
      end
    end else begin
      r_vld     <= w_vld_nxt;
      r_trow[0] <= r_row;
      r_tcol[0] <= r_col;
      for (int i = 1; i < LATENCY; i++) begin
        r_trow[i] <= r_trow[i-1];
        r_tcol[i] <= r_tcol[i-1];
      end
    end
  end
  assign o_busy         = r_state != S_IDLE;
  assign o_done         = r_state == S_DONE;
  assign o_issue        = w_issue;
  assign o_row_idx      = r_row;
  assign o_col_idx      = r_col;
  assign o_result_valid = r_vld[LATENCY-1];
  assign o_result_row   = r_trow[LATENCY-1];
  assign o_result_col   = r_tcol[LATENCY-1];
endmodule
